// File: rtl/ofmap_bank_scheduler_if.sv
// Handshake bundle between the ofmap bank scheduler and its neighbours:
// the config port, the compute FSM and the ofmap readout FSM.
interface ofmap_bank_scheduler_if #(
  parameter int TILE_CNT_WID = 16
);
  logic                    config_en;
  logic [TILE_CNT_WID-1:0] config_num_tiles;
  logic                    compute_bank_done;
  logic                    read_bank_ready_to_switch;
  logic                    switch;
  logic                    one_read_bank_done;
  logic                    ready_to_switch;
  logic                    start_new_read_bank;
  logic                    start_compute_bank;
  logic                    layer_done;
  logic                    busy;
  logic [TILE_CNT_WID-1:0] tiles_read;
  logic                    protocol_err;

  modport master (
    output config_en, config_num_tiles, compute_bank_done,
           read_bank_ready_to_switch, switch, one_read_bank_done,
    input  ready_to_switch, start_new_read_bank, start_compute_bank,
           layer_done, busy, tiles_read, protocol_err
  );

  modport slave (
    input  config_en, config_num_tiles, compute_bank_done,
           read_bank_ready_to_switch, switch, one_read_bank_done,
    output ready_to_switch, start_new_read_bank, start_compute_bank,
           layer_done, busy, tiles_read, protocol_err
  );
endinterface

// File: rtl/ofmap_bank_scheduler.sv
// Accumulator double-buffer scheduler: hands banks from the compute side to
// the ofmap readout side and counts filled/drained tiles for one layer.
module ofmap_bank_scheduler #(
  parameter int TILE_CNT_WID = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ofmap_bank_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_SYNC,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [TILE_CNT_WID-1:0] num_tiles_q;
  logic [TILE_CNT_WID-1:0] wr_cnt;
  logic [TILE_CNT_WID-1:0] rd_cnt;
  logic                    compute_busy;
  logic                    fill_pending;
  logic                    protocol_err_q;

  logic config_accept;
  logic wr_more;
  logic fill_evt;
  logic drain_ok;
  logic launch_compute;

  assign config_accept  = (state_q == S_IDLE) && bus.config_en &&
                          (bus.config_num_tiles != '0);
  assign wr_more        = (wr_cnt < num_tiles_q);
  assign fill_evt       = bus.compute_bank_done && compute_busy;
  assign drain_ok       = (rd_cnt < wr_cnt) && (rd_cnt < num_tiles_q);
  assign launch_compute = (state_q == S_LAUNCH) ||
                          ((state_q == S_RELEASE) && wr_more);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d                 = state_q;
    bus.ready_to_switch     = 1'b0;
    bus.start_new_read_bank = 1'b0;
    bus.start_compute_bank  = launch_compute;
    bus.layer_done          = 1'b0;
    bus.busy                = (state_q != S_IDLE);
    bus.tiles_read          = rd_cnt;
    bus.protocol_err        = protocol_err_q;

    case (state_q)
      S_IDLE:    if (config_accept) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_RUN;
      S_RUN: begin
        // A filled bank waiting for a free reader beats the end-of-layer test.
        if (fill_pending && bus.read_bank_ready_to_switch) state_d = S_SYNC;
        else if (rd_cnt == num_tiles_q)                     state_d = S_DONE;
      end
      S_SYNC: begin
        bus.ready_to_switch = 1'b1;
        if (bus.switch) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        bus.start_new_read_bank = 1'b1;
        state_d                 = S_RUN;
      end
      S_DONE: begin
        bus.layer_done = 1'b1;
        state_d        = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: within this block the last non-blocking assignment to a register
  // wins, which is how the event priorities below are expressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_tiles_q    <= '0;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      compute_busy   <= 1'b0;
      fill_pending   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (bus.compute_bank_done) begin
        if (compute_busy) begin
          if (wr_more) wr_cnt <= wr_cnt + 1'b1;
          compute_busy <= 1'b0;
        end else begin
          protocol_err_q <= 1'b1;
        end
      end

      // Clear-by-switch then set-by-fill: a fill in the swap cycle survives.
      if ((state_q == S_SYNC) && bus.switch) fill_pending <= 1'b0;
      if (fill_evt)                          fill_pending <= 1'b1;

      if (bus.one_read_bank_done) begin
        if (drain_ok) rd_cnt         <= rd_cnt + 1'b1;
        else          protocol_err_q <= 1'b1;
      end

      if (bus.switch && (state_q != S_SYNC)) protocol_err_q <= 1'b1;

      if (launch_compute) compute_busy <= 1'b1;

      if (config_accept) begin
        num_tiles_q <= bus.config_num_tiles;
        wr_cnt      <= '0;
        rd_cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_bank_scheduler.sv
// Self-checking bench: randomized compute/readout agents around the scheduler,
// checked against a transaction-level model of bank fills, swaps and drains.
module tb_ofmap_bank_scheduler;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ofmap_bank_scheduler_if #(.TILE_CNT_WID(W)) bus ();

  ofmap_bank_scheduler #(.TILE_CNT_WID(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.config_en                 = 1'b0;
    bus.config_num_tiles          = '0;
    bus.compute_bank_done         = 1'b0;
    bus.read_bank_ready_to_switch = 1'b1;
    bus.switch                    = 1'b0;
    bus.one_read_bank_done        = 1'b0;
  endtask

  function automatic logic [W+5:0] all_outs();
    return {bus.ready_to_switch, bus.start_new_read_bank, bus.start_compute_bank,
            bus.layer_done, bus.busy, bus.protocol_err, bus.tiles_read};
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_tiles();
    @(negedge clk);
    bus.config_num_tiles = '0;
    bus.config_en        = 1'b1;
    @(negedge clk);
    bus.config_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.start_compute_bank !== 1'b0) begin
        errors++;
        $display("FAIL zero_tiles_idle: busy=%b start_compute=%b expected 0 0",
                 bus.busy, bus.start_compute_bank);
      end
      @(negedge clk);
    end
  endtask

  // Runs one complete layer with compute/readout agents whose latencies are
  // drawn from [cmin,cmax] and [rmin,rmax]. The model tracks how many banks
  // were started, filled, swapped and drained and checks every DUT pulse
  // against those counts.
  task automatic run_layer(input int num, input int cmin, input int cmax,
                           input int rmin, input int rmax, input string name);
    int  starts = 0, filled = 0, swaps = 0, drained = 0, dones = 0;
    int  ctimer = 0, rtimer = 0, swtimer = -1;
    bit  comp_active = 0, read_busy = 0, finished = 0;
    bit  saw_start, saw_new_read;
    int  cyc = 0;

    @(negedge clk);
    bus.config_num_tiles = W'(num);
    bus.config_en        = 1'b1;
    @(negedge clk);
    bus.config_en = 1'b0;
    checks++;
    if (bus.start_compute_bank !== 1'b1) begin
      errors++;
      $display("FAIL %s launch_latency: start_compute=%b expected 1", name,
               bus.start_compute_bank);
    end

    while (!finished && cyc < 4000) begin
      saw_start    = bus.start_compute_bank;
      saw_new_read = bus.start_new_read_bank;

      if (saw_start) begin
        checks++;
        if (comp_active || starts >= num) begin
          errors++;
          $display("FAIL %s start_compute: starts=%0d busy=%0d expected <%0d idle",
                   name, starts, comp_active, num);
        end
        starts++;
      end
      if (bus.ready_to_switch) begin
        checks++;
        if (read_busy || filled != swaps + 1) begin
          errors++;
          $display("FAIL %s ready_to_switch: reader_busy=%0d pending=%0d expected 0 1",
                   name, read_busy, filled - swaps);
        end
      end
      if (saw_new_read) begin
        checks++;
        if (bus.switch !== 1'b1 || bus.start_compute_bank !== (filled < num)) begin
          errors++;
          $display("FAIL %s release: switch=%b start_compute=%b expected 1 %b",
                   name, bus.switch, bus.start_compute_bank, filled < num);
        end
      end
      checks++;
      if (bus.tiles_read !== W'(drained)) begin
        errors++;
        $display("FAIL %s tiles_read: got %0d expected %0d", name, bus.tiles_read, drained);
      end
      if (bus.layer_done) begin
        checks++;
        if (drained != num || dones != 0) begin
          errors++;
          $display("FAIL %s layer_done: drained=%0d dones=%0d expected %0d 0",
                   name, drained, dones, num);
        end
        dones++;
      end else if (dones > 0) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_done: got %b expected 0", name, bus.busy);
        end
        finished = 1;
      end

      bus.compute_bank_done  = 1'b0;
      bus.one_read_bank_done = 1'b0;
      bus.switch             = 1'b0;

      if (comp_active) begin
        if (ctimer <= 1) begin
          bus.compute_bank_done = 1'b1;
          comp_active           = 0;
          filled++;
        end else ctimer--;
      end
      if (read_busy) begin
        if (rtimer <= 1) begin
          bus.one_read_bank_done = 1'b1;
          read_busy              = 0;
          drained++;
        end else rtimer--;
      end
      if (swtimer == 0) begin
        bus.switch = 1'b1;
        swaps++;
        swtimer = -1;
      end else if (swtimer > 0) swtimer--;

      if (saw_start) begin
        comp_active = 1;
        ctimer      = int'($urandom_range(cmax, cmin));
      end
      if (saw_new_read) begin
        read_busy = 1;
        rtimer    = int'($urandom_range(rmax, rmin));
      end
      if (bus.ready_to_switch && swtimer < 0 && !bus.switch)
        swtimer = int'($urandom_range(2, 0));
      bus.read_bank_ready_to_switch = !read_busy;

      @(negedge clk);
      cyc++;
    end

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: layer not finished after %0d cycles", name, cyc);
    end
    checks++;
    if (starts != num || swaps != num || dones != 1 || bus.tiles_read !== W'(num) ||
        bus.protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL %s totals: starts=%0d swaps=%0d dones=%0d tiles=%0d err=%b expected %0d %0d 1 %0d 0",
               name, starts, swaps, dones, bus.tiles_read, bus.protocol_err, num, num, num);
    end
    idle_inputs();
  endtask

  task automatic test_single_tile();
    run_layer(1, 1, 3, 1, 3, "single_tile");
  endtask

  task automatic test_compute_fast();
    run_layer(3, 1, 2, 6, 12, "compute_fast");
  endtask

  task automatic test_read_fast();
    run_layer(3, 6, 12, 1, 2, "read_fast");
  endtask

  task automatic test_random_layers();
    for (int i = 0; i < 5; i++)
      run_layer(int'($urandom_range(6, 1)), 1, int'($urandom_range(8, 1)),
                1, int'($urandom_range(8, 1)), "random_layer");
  endtask

  task automatic test_protocol_err();
    do_reset();
    bus.compute_bank_done = 1'b1;
    @(negedge clk);
    bus.compute_bank_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.busy !== 1'b0 || bus.tiles_read !== '0) begin
      errors++;
      $display("FAIL err_idle_fill: err=%b busy=%b tiles=%0d expected 1 0 0",
               bus.protocol_err, bus.busy, bus.tiles_read);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", bus.protocol_err);
    end

    do_reset();
    bus.config_num_tiles = W'(2);
    bus.config_en        = 1'b1;
    @(negedge clk);
    bus.config_en = 1'b0;
    @(negedge clk);
    bus.switch = 1'b1;
    @(negedge clk);
    bus.switch = 1'b0;
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.busy !== 1'b1 || bus.ready_to_switch !== 1'b0 ||
        bus.start_new_read_bank !== 1'b0 || bus.tiles_read !== '0) begin
      errors++;
      $display("FAIL err_run_switch: err=%b busy=%b rts=%b snrb=%b tiles=%0d expected 1 1 0 0 0",
               bus.protocol_err, bus.busy, bus.ready_to_switch, bus.start_new_read_bank,
               bus.tiles_read);
    end
    do_reset();
  endtask

  task automatic test_reset_in_sync();
    int wait_cyc = 0;
    do_reset();
    bus.config_num_tiles = W'(2);
    bus.config_en        = 1'b1;
    @(negedge clk);
    bus.config_en = 1'b0;
    @(negedge clk);
    bus.compute_bank_done = 1'b1;
    @(negedge clk);
    bus.compute_bank_done = 1'b0;
    while (bus.ready_to_switch !== 1'b1 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (bus.ready_to_switch !== 1'b1) begin
      errors++;
      $display("FAIL sync_reach: ready_to_switch=%b expected 1", bus.ready_to_switch);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_in_sync: got %h expected 0", all_outs());
    end
    run_layer(2, 1, 4, 1, 4, "after_sync_reset");
  endtask

  initial begin
    test_reset();
    test_zero_tiles();
    test_single_tile();
    test_compute_fast();
    test_read_fast();
    test_random_layers();
    test_protocol_err();
    test_reset_in_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
